// File: rtl/proc_io_hub_pkg.sv
// rtl/proc_io_hub_pkg.sv - shared defaults and width/slice helpers for the I/O hub
package proc_io_pkg;

    localparam int NUBITS_DEF = 16;
    localparam int NUIOIN_DEF = 2;
    localparam int NUIOOU_DEF = 2;
    localparam int FDEPTH_DEF = 4;

    localparam int INW  = $clog2(NUIOIN_DEF);
    localparam int OUW  = $clog2(NUIOOU_DEF);
    localparam int PTRW = $clog2(FDEPTH_DEF);

    // Address width that never collapses to zero bits.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of channel k inside a flattened channel bus.
    function automatic int chan_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/proc_io_hub_if.sv
// rtl/proc_io_hub_if.sv - core-side access bus plus external channel streams of the I/O hub
interface proc_io_hub_if
    import proc_io_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEF,
    parameter int NUIOIN = NUIOIN_DEF,
    parameter int NUIOOU = NUIOOU_DEF
);
    localparam int AW_IN = addr_w(NUIOIN);
    localparam int AW_OU = addr_w(NUIOOU);

    logic                     req_in;
    logic [AW_IN-1:0]         addr_in;
    logic [NUBITS-1:0]        io_in;
    logic                     out_en;
    logic [AW_OU-1:0]         addr_out;
    logic [NUBITS-1:0]        io_out;
    logic                     stall;
    logic                     itr;
    logic [NUIOIN-1:0]        itr_mask;
    logic [NUIOIN*NUBITS-1:0] in_data;
    logic [NUIOIN-1:0]        in_valid;
    logic [NUIOIN-1:0]        in_ready;
    logic [NUIOOU*NUBITS-1:0] ou_data;
    logic [NUIOOU-1:0]        ou_valid;
    logic [NUIOOU-1:0]        ou_ready;
    logic                     err;

    modport slave (
        input  req_in, addr_in, out_en, addr_out, io_out, itr_mask,
               in_data, in_valid, ou_ready,
        output io_in, stall, itr, in_ready, ou_data, ou_valid, err
    );

    modport master (
        output req_in, addr_in, out_en, addr_out, io_out, itr_mask,
               in_data, in_valid, ou_ready,
        input  io_in, stall, itr, in_ready, ou_data, ou_valid, err
    );

endinterface

// File: rtl/proc_io_hub_fifo.sv
// rtl/proc_io_hub_fifo.sv - first-word-fall-through channel FIFO with occupancy count
module io_fifo #(
    parameter int NBDATA = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [NBDATA-1:0]          din_i,
    output logic [NBDATA-1:0]          head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTRW = $clog2(DEPTH);

    logic [NBDATA-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]   wr_q, rd_q;
    logic [PTRW:0]     cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == (PTRW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // Overflow/underflow requests are dropped here so callers cannot corrupt state.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/proc_io_hub.sv
// rtl/proc_io_hub.sv - buffered multi-channel I/O hub between the processor core and external streams
module proc_io_hub
    import proc_io_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEF,
    parameter int NUIOIN = NUIOIN_DEF,
    parameter int NUIOOU = NUIOOU_DEF,
    parameter int FDEPTH = FDEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    proc_io_hub_if.slave bus
);
    localparam int AW_IN = addr_w(NUIOIN);
    localparam int AW_OU = addr_w(NUIOOU);
    localparam int CW    = $clog2(FDEPTH) + 1;

    logic [NUIOIN-1:0]              in_full, in_empty, in_push, in_pop, in_sel, in_first;
    logic [NUIOIN-1:0][NUBITS-1:0]  in_head;
    logic [NUIOIN-1:0][CW-1:0]      in_cnt;
    logic [NUIOOU-1:0]              ou_full, ou_empty, ou_push, ou_pop, ou_sel;
    logic [NUIOOU-1:0][NUBITS-1:0]  ou_head;
    logic [NUIOOU-1:0][CW-1:0]      ou_cnt;

    logic              rd_range, wr_range, rd_empty, wr_full;
    logic              rd_stall, wr_stall, core_go;
    logic [NUBITS-1:0] rd_head;

    logic              run_q;
    logic [NUBITS-1:0] io_in_q, io_in_d;
    logic              itr_q, itr_d;
    logic              err_q, err_d;
    logic              unused_ou_cnt;

    always_comb begin
        in_sel   = '0;
        rd_head  = '0;
        rd_empty = 1'b0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (bus.addr_in == AW_IN'(k)) begin
                in_sel[k] = 1'b1;
                rd_head   = in_head[k];
                rd_empty  = in_empty[k];
            end
        end
    end

    always_comb begin
        ou_sel  = '0;
        wr_full = 1'b0;
        for (int j = 0; j < NUIOOU; j++) begin
            if (bus.addr_out == AW_OU'(j)) begin
                ou_sel[j] = 1'b1;
                wr_full   = ou_full[j];
            end
        end
    end

    assign rd_range = |in_sel;
    assign wr_range = |ou_sel;
    assign rd_stall = bus.req_in & rd_range & rd_empty;
    assign wr_stall = bus.out_en & wr_range & wr_full;
    // A stall on either side freezes both core accesses; the core replays the pair.
    assign core_go  = ~(rd_stall | wr_stall);
    assign bus.stall = rst & (rd_stall | wr_stall);

    assign bus.in_ready = {NUIOIN{run_q}} & ~in_full;
    assign in_push      = bus.in_valid & bus.in_ready;
    assign in_pop       = in_sel & {NUIOIN{bus.req_in & core_go}};
    assign ou_push      = ou_sel & {NUIOOU{bus.out_en & core_go}};
    assign ou_pop       = ~ou_empty & bus.ou_ready;
    assign bus.ou_valid = ~ou_empty;
    assign bus.ou_data  = ou_head;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        io_fifo #(.NBDATA(NUBITS), .DEPTH(FDEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst),
            .push_i  (in_push[k]),
            .pop_i   (in_pop[k]),
            .din_i   (bus.in_data[chan_lo(k, NUBITS) +: NUBITS]),
            .head_o  (in_head[k]),
            .full_o  (in_full[k]),
            .empty_o (in_empty[k]),
            .count_o (in_cnt[k])
        );
    end

    for (genvar j = 0; j < NUIOOU; j++) begin : g_ou
        io_fifo #(.NBDATA(NUBITS), .DEPTH(FDEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst),
            .push_i  (ou_push[j]),
            .pop_i   (ou_pop[j]),
            .din_i   (bus.io_out),
            .head_o  (ou_head[j]),
            .full_o  (ou_full[j]),
            .empty_o (ou_empty[j]),
            .count_o (ou_cnt[j])
        );
    end

    assign unused_ou_cnt = ^ou_cnt;

    // Empty-to-non-empty only happens through a push into a zero-count FIFO.
    always_comb begin
        for (int k = 0; k < NUIOIN; k++) begin
            in_first[k] = in_push[k] & bus.itr_mask[k] & (in_cnt[k] == '0);
        end
    end

    always_comb begin
        io_in_d = io_in_q;
        if (bus.req_in & core_go) io_in_d = rd_range ? rd_head : '0;
        itr_d = |in_first;
        err_d = err_q | (bus.req_in & ~rd_range) | (bus.out_en & ~wr_range);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q   <= 1'b0;
            io_in_q <= '0;
            itr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            io_in_q <= io_in_d;
            itr_q   <= itr_d;
            err_q   <= err_d;
        end
    end

    assign bus.io_in = io_in_q;
    assign bus.itr   = itr_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_proc_io_hub.sv
// tb/tb_proc_io_hub.sv - scoreboard bench for proc_io_hub (2-channel and 3-input-channel instances)
module tb_proc_io_hub;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    proc_io_hub_if #(.NUBITS(16), .NUIOIN(2), .NUIOOU(2)) bus ();
    proc_io_hub_if #(.NUBITS(16), .NUIOIN(3), .NUIOOU(2)) bus3 ();

    proc_io_hub #(.NUBITS(16), .NUIOIN(2), .NUIOOU(2), .FDEPTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    proc_io_hub #(.NUBITS(16), .NUIOIN(3), .NUIOOU(2), .FDEPTH(4)) u_oor (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_o[$];
    logic [15:0] want;

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 2'b00) begin n_bad++; $display("FAIL reset_in_ready: got %b want 00", bus.in_ready); end
        n_cmp++; if (bus.io_in !== 16'h0000) begin n_bad++; $display("FAIL reset_io_in: got %h want 0000", bus.io_in); end
        n_cmp++; if (bus.ou_valid !== 2'b00) begin n_bad++; $display("FAIL reset_ou_valid: got %b want 00", bus.ou_valid); end
        n_cmp++; if (bus.itr !== 1'b0) begin n_bad++; $display("FAIL reset_itr: got %b want 0", bus.itr); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 2'b00;
        @(negedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 2'b11) begin n_bad++; $display("FAIL release_in_ready: got %b want 11", bus.in_ready); end
        n_cmp++; if (bus3.in_ready !== 3'b111) begin n_bad++; $display("FAIL release_in_ready3: got %b want 111", bus3.in_ready); end
    endtask

    task automatic test_read_stall();
        @(negedge clk);
        bus.req_in = 1'b1;
        bus.addr_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL read_stall_%0d: got %b want 1", i, bus.stall); end
            @(negedge clk);
        end
        bus.in_data[31:16] = 16'h00A5;
        bus.in_valid = 2'b10;
        exp_q.push_back(16'h00A5);
        @(negedge clk);
        bus.in_valid = 2'b00;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL read_stall_drop: got %b want 0", bus.stall); end
        @(negedge clk);
        #1;
        want = exp_q.pop_front();
        n_cmp++; if (bus.io_in !== want) begin n_bad++; $display("FAIL read_data: got %h want %h", bus.io_in, want); end
        bus.req_in = 1'b0;
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        bus.ou_ready = 2'b00;
        bus.out_en = 1'b1;
        bus.addr_out = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            bus.io_out = 16'(v);
            exp_o.push_back(16'(v));
            #1;
            n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL wr_fill_stall_%0d: got %b want 0", v, bus.stall); end
            @(negedge clk);
        end
        bus.io_out = 16'h0005;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL wr_full_stall: got %b want 1", bus.stall); end
        @(negedge clk);
        bus.ou_ready = 2'b01;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL wr_full_pop_stall: got %b want 1", bus.stall); end
        want = exp_o.pop_front();
        n_cmp++; if (bus.ou_data[15:0] !== want) begin n_bad++; $display("FAIL ou_head_first: got %h want %h", bus.ou_data[15:0], want); end
        @(negedge clk);
        bus.ou_ready = 2'b00;
        exp_o.push_back(16'h0005);
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL wr_slot_free_stall: got %b want 0", bus.stall); end
        @(negedge clk);
        bus.out_en = 1'b0;
        bus.ou_ready = 2'b01;
        #1;
        for (int i = 0; i < 8 && bus.ou_valid[0]; i++) begin
            if (exp_o.size() == 0) begin
                n_cmp++; n_bad++; $display("FAIL ou_drain_extra: got %h want none", bus.ou_data[15:0]);
            end else begin
                want = exp_o.pop_front();
                n_cmp++; if (bus.ou_data[15:0] !== want) begin n_bad++; $display("FAIL ou_drain: got %h want %h", bus.ou_data[15:0], want); end
            end
            @(negedge clk);
            #1;
        end
        n_cmp++; if (exp_o.size() != 0) begin n_bad++; $display("FAIL ou_drain_left: got %0d words left want 0", exp_o.size()); exp_o.delete(); end
        bus.ou_ready = 2'b00;
    endtask

    task automatic test_full_input();
        @(negedge clk);
        bus.in_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            bus.in_data[15:0] = 16'h0010 + 16'(i);
            exp_q.push_back(16'h0010 + 16'(i));
            @(negedge clk);
        end
        #1;
        n_cmp++; if (bus.in_ready[0] !== 1'b0) begin n_bad++; $display("FAIL in_full_ready: got %b want 0", bus.in_ready[0]); end
        bus.in_data[15:0] = 16'h0099;
        bus.req_in = 1'b1;
        bus.addr_in = 1'b0;
        @(negedge clk);
        bus.in_valid = 2'b00;
        #1;
        n_cmp++; if (bus.in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL in_freed_ready: got %b want 1", bus.in_ready[0]); end
        want = exp_q.pop_front();
        n_cmp++; if (bus.io_in !== want) begin n_bad++; $display("FAIL in_full_pop: got %h want %h", bus.io_in, want); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            want = exp_q.pop_front();
            n_cmp++; if (bus.io_in !== want) begin n_bad++; $display("FAIL in_drain_%0d: got %h want %h", i, bus.io_in, want); end
        end
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL in_drained_stall: got %b want 1", bus.stall); end
        bus.req_in = 1'b0;
    endtask

    task automatic test_interrupt();
        @(negedge clk);
        bus.itr_mask = 2'b10;
        bus.in_data = 32'h0000_0C00;
        bus.in_valid = 2'b01;
        exp_q.push_back(16'h0C00);
        @(negedge clk);
        bus.in_valid = 2'b00;
        #1;
        n_cmp++; if (bus.itr !== 1'b0) begin n_bad++; $display("FAIL itr_masked: got %b want 0", bus.itr); end
        bus.in_data[31:16] = 16'h0C11;
        bus.in_valid = 2'b10;
        exp_q.push_back(16'h0C11);
        @(negedge clk);
        bus.in_valid = 2'b00;
        #1;
        n_cmp++; if (bus.itr !== 1'b1) begin n_bad++; $display("FAIL itr_pulse: got %b want 1", bus.itr); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.itr !== 1'b0) begin n_bad++; $display("FAIL itr_one_cycle: got %b want 0", bus.itr); end
        bus.in_data[31:16] = 16'h0C12;
        bus.in_valid = 2'b10;
        exp_q.push_back(16'h0C12);
        @(negedge clk);
        bus.in_valid = 2'b00;
        #1;
        n_cmp++; if (bus.itr !== 1'b0) begin n_bad++; $display("FAIL itr_nonempty: got %b want 0", bus.itr); end
        bus.req_in = 1'b1;
        bus.addr_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.addr_in = 1'b1;
            #1;
            want = exp_q.pop_front();
            n_cmp++; if (bus.io_in !== want) begin n_bad++; $display("FAIL itr_drain_%0d: got %h want %h", i, bus.io_in, want); end
        end
        bus.req_in = 1'b0;
        bus.itr_mask = 2'b11;
        bus.in_data = 32'h0D11_0D00;
        bus.in_valid = 2'b11;
        exp_q.push_back(16'h0D00);
        @(negedge clk);
        bus.in_valid = 2'b00;
        #1;
        n_cmp++; if (bus.itr !== 1'b1) begin n_bad++; $display("FAIL itr_dual: got %b want 1", bus.itr); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.itr !== 1'b0) begin n_bad++; $display("FAIL itr_dual_single: got %b want 0", bus.itr); end
        bus.itr_mask = 2'b00;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.req_in = 1'b1;
        bus.addr_in = 1'b0;
        bus.out_en = 1'b1;
        bus.addr_out = 1'b1;
        bus.io_out = 16'hBEEF;
        exp_o.push_back(16'hBEEF);
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got %b want 0", bus.stall); end
        @(negedge clk);
        bus.io_out = 16'hCAFE;
        #1;
        want = exp_q.pop_front();
        n_cmp++; if (bus.io_in !== want) begin n_bad++; $display("FAIL b2b_read: got %h want %h", bus.io_in, want); end
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL b2b_read_stall: got %b want 1", bus.stall); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.ou_valid !== 2'b10) begin n_bad++; $display("FAIL b2b_ou_valid: got %b want 10", bus.ou_valid); end
        bus.req_in = 1'b0;
        bus.out_en = 1'b0;
        bus.ou_ready = 2'b10;
        #1;
        for (int i = 0; i < 8 && bus.ou_valid[1]; i++) begin
            if (exp_o.size() == 0) begin
                n_cmp++; n_bad++; $display("FAIL b2b_extra_write: got %h want none", bus.ou_data[31:16]);
            end else begin
                want = exp_o.pop_front();
                n_cmp++; if (bus.ou_data[31:16] !== want) begin n_bad++; $display("FAIL b2b_write: got %h want %h", bus.ou_data[31:16], want); end
            end
            @(negedge clk);
            #1;
        end
        n_cmp++; if (exp_o.size() != 0) begin n_bad++; $display("FAIL b2b_left: got %0d words left want 0", exp_o.size()); exp_o.delete(); end
        bus.ou_ready = 2'b00;
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        bus3.in_data[47:32] = 16'h1234;
        bus3.in_valid = 3'b100;
        @(negedge clk);
        bus3.in_valid = 3'b000;
        bus3.req_in = 1'b1;
        bus3.addr_in = 2'd2;
        @(negedge clk);
        bus3.addr_in = 2'd3;
        #1;
        n_cmp++; if (bus3.io_in !== 16'h1234) begin n_bad++; $display("FAIL oor_pre_read: got %h want 1234", bus3.io_in); end
        n_cmp++; if (bus3.stall !== 1'b0) begin n_bad++; $display("FAIL oor_stall: got %b want 0", bus3.stall); end
        n_cmp++; if (bus3.err !== 1'b0) begin n_bad++; $display("FAIL oor_err_pre: got %b want 0", bus3.err); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus3.io_in !== 16'h0000) begin n_bad++; $display("FAIL oor_read_zero: got %h want 0000", bus3.io_in); end
        n_cmp++; if (bus3.err !== 1'b1) begin n_bad++; $display("FAIL oor_err_set: got %b want 1", bus3.err); end
        bus3.req_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bus3.err !== 1'b1) begin n_bad++; $display("FAIL oor_err_sticky: got %b want 1", bus3.err); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.out_en = 1'b1;
        bus.addr_out = 1'b0;
        bus.io_out = 16'h7777;
        @(negedge clk);
        bus.out_en = 1'b0;
        bus.req_in = 1'b1;
        bus.addr_in = 1'b0;
        #1;
        n_cmp++; if (bus.ou_valid[0] !== 1'b1) begin n_bad++; $display("FAIL mid_ou_loaded: got %b want 1", bus.ou_valid[0]); end
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL mid_stall_pre: got %b want 1", bus.stall); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL mid_stall_async: got %b want 0", bus.stall); end
        n_cmp++; if (bus.ou_valid !== 2'b00) begin n_bad++; $display("FAIL mid_ou_flush: got %b want 00", bus.ou_valid); end
        n_cmp++; if (bus3.err !== 1'b0) begin n_bad++; $display("FAIL mid_err_clear: got %b want 0", bus3.err); end
        @(negedge clk);
        rst = 1'b1;
        bus.addr_in = 1'b1;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL mid_in_flush: got %b want 1", bus.stall); end
        bus.req_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1);
    end

    initial begin
        bus.req_in = 1'b0;   bus.addr_in = '0;   bus.out_en = 1'b0;  bus.addr_out = '0;
        bus.io_out = '0;     bus.itr_mask = '0;  bus.in_data = '0;   bus.in_valid = '0;
        bus.ou_ready = '0;
        bus3.req_in = 1'b0;  bus3.addr_in = '0;  bus3.out_en = 1'b0; bus3.addr_out = '0;
        bus3.io_out = '0;    bus3.itr_mask = '0; bus3.in_data = '0;  bus3.in_valid = '0;
        bus3.ou_ready = '0;

        test_reset();
        test_read_stall();
        test_back_pressure();
        test_full_input();
        test_interrupt();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
